// File: rtl/sp_ram_bist_pkg.sv
// rtl/sp_ram_bist_pkg.sv - March C- state encoding and per-element constants for sp_ram_bist.
package sp_ram_bist_pkg;

  localparam int NUM_ELEMS = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_E0_WR,
    ST_E1_RD,
    ST_E1_WR,
    ST_E2_RD,
    ST_E2_WR,
    ST_E3_RD,
    ST_E3_WR,
    ST_E4_RD,
    ST_E4_WR,
    ST_E5_RD,
    ST_LAST_CMP
  } bist_state_e;

  // Bit i describes march element i: address direction, read background, write background.
  localparam logic [NUM_ELEMS-1:0] ELEM_UP      = 6'b100111;
  localparam logic [NUM_ELEMS-1:0] ELEM_RD_ONES = 6'b010100;
  localparam logic [NUM_ELEMS-1:0] ELEM_WR_ONES = 6'b001010;

  function automatic logic [2:0] elem_of(input bist_state_e s);
    case (s)
      ST_E1_RD, ST_E1_WR: return 3'd1;
      ST_E2_RD, ST_E2_WR: return 3'd2;
      ST_E3_RD, ST_E3_WR: return 3'd3;
      ST_E4_RD, ST_E4_WR: return 3'd4;
      ST_E5_RD, ST_LAST_CMP: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic int inj_bit_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_bist_if.sv
// rtl/sp_ram_bist_if.sv - Functional port, BIST control/status and fault-injection bundle.
interface sp_ram_bist_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
);
  import sp_ram_bist_pkg::*;

  localparam int IB_W = inj_bit_w(DATA_W);

  logic              write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              bist_start;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [CNT_W-1:0]  fail_count;
  logic              inj_en;
  logic [ADDR_W-1:0] inj_addr;
  logic [IB_W-1:0]   inj_bit;

  modport master (
    output write_en, ram_addr, data_in, bist_start, inj_en, inj_addr, inj_bit,
    input  data_out, bist_busy, bist_done, bist_fail, fail_addr, fail_count
  );

  modport slave (
    input  write_en, ram_addr, data_in, bist_start, inj_en, inj_addr, inj_bit,
    output data_out, bist_busy, bist_done, bist_fail, fail_addr, fail_count
  );

endinterface

// File: rtl/sp_ram_array.sv
// rtl/sp_ram_array.sv - Single-port storage with registered read and stuck-at-1 read mux.
module sp_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int IB_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [IB_W-1:0]   inj_bit,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] inj_mask;

  // The fault only corrupts what is read out; stored contents stay intact.
  always_comb begin
    inj_mask = '0;
    if (inj_en && (addr == inj_addr)) begin
      inj_mask = DATA_W'(1) << inj_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr] | inj_mask;
    end
  end

endmodule

// File: rtl/sp_ram_bist.sv
// rtl/sp_ram_bist.sv - Single-port RAM with March C- BIST engine sharing the port.
module sp_ram_bist
  import sp_ram_bist_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  sp_ram_bist_if.slave bus
);

  localparam int IB_W = inj_bit_w(DATA_W);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  bist_state_e       state;
  bist_state_e       state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        elem;
  logic              up;
  logic              at_end;
  logic              start_ok;

  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  logic              cmp_en;
  logic              cmp_ones;
  logic [ADDR_W-1:0] cmp_addr;
  logic              miscmp;

  logic              done_q;
  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [CNT_W-1:0]  fail_count_q;

  always_comb begin
    elem     = elem_of(state);
    up       = ELEM_UP[elem];
    at_end   = up ? (addr == ADDR_LAST) : (addr == '0);
    start_ok = (state == ST_IDLE) && bus.bist_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (bus.bist_start) state_nxt = ST_E0_WR;
      ST_E0_WR:    if (at_end) state_nxt = ST_E1_RD;
      ST_E1_RD:    state_nxt = ST_E1_WR;
      ST_E1_WR:    state_nxt = at_end ? ST_E2_RD : ST_E1_RD;
      ST_E2_RD:    state_nxt = ST_E2_WR;
      ST_E2_WR:    state_nxt = at_end ? ST_E3_RD : ST_E2_RD;
      ST_E3_RD:    state_nxt = ST_E3_WR;
      ST_E3_WR:    state_nxt = at_end ? ST_E4_RD : ST_E3_RD;
      ST_E4_RD:    state_nxt = ST_E4_WR;
      ST_E4_WR:    state_nxt = at_end ? ST_E5_RD : ST_E4_RD;
      ST_E5_RD:    if (at_end) state_nxt = ST_LAST_CMP;
      ST_LAST_CMP: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // E5 has no write slot, so each read is checked while the next one is issued.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = addr;
    arr_wdata = '0;
    cmp_en    = 1'b0;
    cmp_addr  = addr;
    cmp_ones  = ELEM_RD_ONES[elem];
    case (state)
      ST_IDLE: begin
        arr_we    = bus.write_en;
        arr_re    = !bus.write_en;
        arr_addr  = bus.ram_addr;
        arr_wdata = bus.data_in;
      end
      ST_E0_WR, ST_E1_WR, ST_E2_WR, ST_E3_WR, ST_E4_WR: begin
        arr_we    = 1'b1;
        arr_wdata = {DATA_W{ELEM_WR_ONES[elem]}};
        cmp_en    = (state != ST_E0_WR);
      end
      ST_E1_RD, ST_E2_RD, ST_E3_RD, ST_E4_RD: begin
        arr_re = 1'b1;
      end
      ST_E5_RD: begin
        arr_re   = 1'b1;
        cmp_en   = (addr != '0);
        cmp_addr = addr - 1'b1;
      end
      ST_LAST_CMP: begin
        cmp_en = 1'b1;
      end
      default: begin
        arr_re = 1'b0;
      end
    endcase
    miscmp = cmp_en && (arr_rdata != {DATA_W{cmp_ones}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else begin
      case (state)
        ST_IDLE: addr <= '0;
        ST_E0_WR, ST_E1_WR, ST_E2_WR, ST_E3_WR, ST_E4_WR: begin
          if (at_end) begin
            addr <= ELEM_UP[elem + 3'd1] ? '0 : ADDR_LAST;
          end else if (up) begin
            addr <= addr + 1'b1;
          end else begin
            addr <= addr - 1'b1;
          end
        end
        ST_E5_RD: if (!at_end) addr <= addr + 1'b1;
        default: addr <= addr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else if (start_ok) begin
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else begin
      if (state == ST_LAST_CMP) begin
        done_q <= 1'b1;
      end
      if (miscmp) begin
        if (fail_count_q != {CNT_W{1'b1}}) begin
          fail_count_q <= fail_count_q + 1'b1;
        end
        if (!fail_q) begin
          fail_q      <= 1'b1;
          fail_addr_q <= cmp_addr;
        end
      end
    end
  end

  sp_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .IB_W   (IB_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .we       (arr_we),
    .re       (arr_re),
    .addr     (arr_addr),
    .wdata    (arr_wdata),
    .inj_en   (bus.inj_en),
    .inj_addr (bus.inj_addr),
    .inj_bit  (bus.inj_bit),
    .rdata    (arr_rdata)
  );

  assign bus.data_out   = arr_rdata;
  assign bus.bist_busy  = (state != ST_IDLE);
  assign bus.bist_done  = done_q;
  assign bus.bist_fail  = fail_q;
  assign bus.fail_addr  = fail_addr_q;
  assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_sp_ram_bist.sv
// tb/tb_sp_ram_bist.sv - Directed bench for sp_ram_bist at 8x32 and 16x8 geometries.
module tb_sp_ram_bist;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  sp_ram_bist_if #(.DATA_W(8),  .ADDR_W(5), .CNT_W(8)) b8 ();
  sp_ram_bist_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) b16 ();

  sp_ram_bist #(.DATA_W(8),  .ADDR_W(5), .CNT_W(8)) dut8  (.clk(clk), .rst(rst), .bus(b8));
  sp_ram_bist #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] din;
    logic       ie;
    logic [4:0] ia;
    logic [2:0] ib;
    logic [7:0] exp;
  } fvec_t;

  fvec_t fv [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input bit wide, input logic v);
    if (wide) b16.bist_start = v;
    else      b8.bist_start  = v;
  endtask

  function automatic logic [31:0] get_res(input bit wide, input int which);
    case (which)
      0: return wide ? 32'(b16.bist_busy)  : 32'(b8.bist_busy);
      1: return wide ? 32'(b16.bist_done)  : 32'(b8.bist_done);
      2: return wide ? 32'(b16.bist_fail)  : 32'(b8.bist_fail);
      3: return wide ? 32'(b16.fail_addr)  : 32'(b8.fail_addr);
      default: return wide ? 32'(b16.fail_count) : 32'(b8.fail_count);
    endcase
  endfunction

  task automatic run_bist(input bit wide, input int exp_cyc, input logic exp_fail,
                          input int exp_addr, input int exp_cnt, input string tag);
    int cnt;
    set_start(wide, 1'b1);
    tick();
    set_start(wide, 1'b0);
    check({tag, " busy_at_start"}, get_res(wide, 0), 32'd1);
    for (int k = 1; k < 5; k++) begin
      check($sformatf("%s cleared_at_start_%0d", tag, k), get_res(wide, k), 32'd0);
    end
    cnt = 0;
    while (get_res(wide, 0) == 32'd1 && cnt < 2000) begin
      if (cnt == 20) set_start(wide, 1'b1);
      if (cnt == 21) set_start(wide, 1'b0);
      if (!wide && cnt == 10) begin
        b8.data_in  = 8'hFF;
        b8.ram_addr = 5'd3;
      end
      if (!wide && cnt == 200) begin
        b8.data_in  = 8'h00;
        b8.ram_addr = 5'd0;
      end
      tick();
      cnt++;
    end
    check({tag, " busy_cycles"}, 32'(cnt), 32'(exp_cyc));
    check({tag, " done"},       get_res(wide, 1), 32'd1);
    check({tag, " fail"},       get_res(wide, 2), 32'(exp_fail));
    check({tag, " fail_addr"},  get_res(wide, 3), 32'(exp_addr));
    check({tag, " fail_count"}, get_res(wide, 4), 32'(exp_cnt));
  endtask

  task automatic read8(input logic [4:0] a, input logic [7:0] exp, input string name);
    b8.write_en = 1'b0;
    b8.ram_addr = a;
    tick();
    check(name, 32'(b8.data_out), 32'(exp));
    b8.write_en = 1'b1;
    b8.ram_addr = 5'd0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    b8.write_en = 1'b1;  b8.ram_addr = '0;  b8.data_in = '0;  b8.bist_start = 1'b0;
    b8.inj_en = 1'b0;    b8.inj_addr = '0;  b8.inj_bit = '0;
    b16.write_en = 1'b1; b16.ram_addr = '0; b16.data_in = '0; b16.bist_start = 1'b0;
    b16.inj_en = 1'b0;   b16.inj_addr = '0; b16.inj_bit = '0;

    fv[0] = '{1'b1, 5'd3, 8'hA5, 1'b0, 5'd0, 3'd0, 8'h00};
    fv[1] = '{1'b1, 5'd7, 8'h3C, 1'b0, 5'd0, 3'd0, 8'h00};
    fv[2] = '{1'b0, 5'd3, 8'h00, 1'b0, 5'd0, 3'd0, 8'hA5};
    fv[3] = '{1'b1, 5'd3, 8'h5A, 1'b0, 5'd0, 3'd0, 8'hA5};
    fv[4] = '{1'b0, 5'd7, 8'h00, 1'b0, 5'd0, 3'd0, 8'h3C};
    fv[5] = '{1'b0, 5'd3, 8'h00, 1'b0, 5'd0, 3'd0, 8'h5A};
    fv[6] = '{1'b0, 5'd3, 8'h00, 1'b1, 5'd3, 3'd0, 8'h5B};
    fv[7] = '{1'b0, 5'd7, 8'h00, 1'b1, 5'd3, 3'd0, 8'h3C};
    fv[8] = '{1'b0, 5'd7, 8'h00, 1'b1, 5'd7, 3'd7, 8'hBC};
    fv[9] = '{1'b0, 5'd3, 8'h00, 1'b0, 5'd0, 3'd0, 8'h5A};

    repeat (2) tick();
    check("rst data_out8", 32'(b8.data_out), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rst status8_%0d", k), get_res(1'b0, k), 32'd0);
      check($sformatf("rst status16_%0d", k), get_res(1'b1, k), 32'd0);
    end
    check("rst data_out16", 32'(b16.data_out), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      b8.write_en = fv[i].we;
      b8.ram_addr = fv[i].addr;
      b8.data_in  = fv[i].din;
      b8.inj_en   = fv[i].ie;
      b8.inj_addr = fv[i].ia;
      b8.inj_bit  = fv[i].ib;
      tick();
      check($sformatf("func_vec%0d", i), 32'(b8.data_out), 32'(fv[i].exp));
    end
    b8.write_en = 1'b1; b8.ram_addr = '0; b8.data_in = '0; b8.inj_en = 1'b0;
    tick();

    run_bist(1'b0, 321, 1'b0, 0, 0, "clean8");
    for (int a = 0; a < 32; a++) begin
      read8(5'(a), 8'h00, $sformatf("clean8 readback_%0d", a));
    end

    b8.inj_en = 1'b1; b8.inj_addr = 5'd5; b8.inj_bit = 3'd0;
    run_bist(1'b0, 321, 1'b1, 5, 3, "inj5");
    read8(5'd5, 8'h01, "inj5 read_forced");
    b8.inj_en = 1'b0;
    read8(5'd5, 8'h00, "inj5 storage_intact");

    b8.inj_en = 1'b1; b8.inj_addr = 5'd31; b8.inj_bit = 3'd7;
    run_bist(1'b0, 321, 1'b1, 31, 3, "inj31");

    b8.inj_addr = 5'd5; b8.inj_bit = 3'd0;
    set_start(1'b0, 1'b1);
    tick();
    set_start(1'b0, 1'b0);
    repeat (100) tick();
    check("abort pre busy", get_res(1'b0, 0), 32'd1);
    check("abort pre fail", get_res(1'b0, 2), 32'd1);
    check("abort pre fail_addr", get_res(1'b0, 3), 32'd5);
    check("abort pre fail_count", get_res(1'b0, 4), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("abort post_%0d", k), get_res(1'b0, k), 32'd0);
    end
    check("abort data_out", 32'(b8.data_out), 32'd0);
    b8.inj_en = 1'b0;
    tick();
    run_bist(1'b0, 321, 1'b0, 0, 0, "after_abort");

    run_bist(1'b1, 81, 1'b0, 0, 0, "clean16");
    b16.inj_en = 1'b1; b16.inj_addr = 3'd0; b16.inj_bit = 4'd15;
    run_bist(1'b1, 81, 1'b1, 0, 3, "inj16");
    b16.inj_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
